// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit owning the HI/LO registers.
// Define MDU_FAST_MULT_EN to make MULT/MULTU a single registered multiply.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, nextState;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opB, magA, magB, divSub, quoFinal, remFinal;
    logic [2*WIDTH-1:0] acc, mulNext, divNext, mulRaw, mulFinal;
    logic [WIDTH:0] mulSum, divShift;
    logic isDiv, negQ, negR, divZero;
    logic accept, isMulDiv, isSigned, fastMul, divGe, writeBack;

    always_comb begin
        accept = start && !busy && !flush;
        isMulDiv = !op[2];
        isSigned = !op[0];
        magA = isSigned && src1[WIDTH-1] ? -src1 : src1;
        magB = isSigned && src2[WIDTH-1] ? -src2 : src2;
`ifdef MDU_FAST_MULT_EN
        fastMul = !op[1];
        mulRaw = {{WIDTH{1'b0}}, opB} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
        fastMul = 1'b0;
        mulRaw = acc;
`endif
        // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide
        mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
        mulNext = {mulSum, acc[WIDTH-1:1]};
        divShift = acc[2*WIDTH-1:WIDTH-1];
        divGe = divShift >= {1'b0, opB};
        divSub = divShift[WIDTH-1:0] - opB;
        divNext = divGe ? {divSub, acc[WIDTH-2:0], 1'b1} : {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        mulFinal = negQ ? -mulRaw : mulRaw;
        // a zero divisor leaves the raw all-ones quotient unsigned
        quoFinal = negQ && !divZero ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remFinal = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        writeBack = state == FIX && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = accept && isMulDiv ? (fastMul ? FIX : RUN) : IDLE;
            RUN: nextState = flush ? IDLE : (cnt == CNT_W'(WIDTH - 1) ? FIX : RUN);
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
            done <= 1'b0;
            cnt <= '0;
            opB <= '0;
            acc <= '0;
            isDiv <= 1'b0;
            negQ <= 1'b0;
            negR <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done <= writeBack;
            if (writeBack) {hi, lo} <= isDiv ? {remFinal, quoFinal} : mulFinal;
            if (accept && op == 3'd4) hi <= src1;
            if (accept && op == 3'd5) lo <= src1;
            if (accept && isMulDiv) begin
                cnt <= '0;
                opB <= magB;
                acc <= {{WIDTH{1'b0}}, magA};
                isDiv <= op[1];
                negQ <= isSigned && (src1[WIDTH-1] ^ src2[WIDTH-1]);
                negR <= isSigned && op[1] && src1[WIDTH-1];
                divZero <= src2 == '0;
            end else if (state == RUN) begin
                cnt <= cnt + 1'b1;
                acc <= isDiv ? divNext : mulNext;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit.
// Honours MDU_FAST_MULT_EN for expected multiply latency.
module tb_mul_div_unit;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0] op = 3'd0;
    logic [31:0] src1 = '0, src2 = '0;
    logic busy, done;
    logic [31:0] hi, lo;
    int errors = 0, checks = 0;
    logic [63:0] sbq[$];
    logic [63:0] sbExp;
    logic [31:0] modelHi = '0, modelLo = '0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src1(src1), .src2(src2),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint pa, pb;
        sa = a;
        sb = b;
        pa = sa;
        pb = sb;
        if (o == 3'd0) return pa * pb;
        if (o == 3'd1) return {32'b0, a} * {32'b0, b};
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (o == 3'd3) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) check("unexpected_done", {63'b0, done}, 64'd0);
            else begin
                sbExp = sbq.pop_front();
                check("result", {hi, lo}, sbExp);
            end
        end
    end

    task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] expRes);
        int lat, busyCnt, expLat;
        start = 1'b1;
        op = o;
        src1 = a;
        src2 = b;
        sbq.push_back(expRes);
        {modelHi, modelLo} = expRes;
        @(negedge clk);
        start = 1'b0;
        src1 = $urandom;
        src2 = $urandom;
        check("done_pulse", {63'b0, done}, 64'd0);
        lat = 0;
        busyCnt = 0;
        while (!done && lat < 60) begin
            busyCnt += int'(busy);
            @(negedge clk);
            lat++;
        end
`ifdef MDU_FAST_MULT_EN
        expLat = o < 3'd2 ? 1 : 33;
`else
        expLat = 33;
`endif
        check("latency", 64'(lat), 64'(expLat));
        check("busy_cycles", 64'(busyCnt), 64'(expLat));
        check("busy_at_done", {63'b0, busy}, 64'd0);
    endtask

    task automatic runMove(input logic toHi, input logic [31:0] d);
        start = 1'b1;
        op = toHi ? 3'd4 : 3'd5;
        src1 = d;
        if (toHi) modelHi = d;
        else modelLo = d;
        @(negedge clk);
        start = 1'b0;
        check("mt_hi", {32'b0, hi}, {32'b0, modelHi});
        check("mt_lo", {32'b0, lo}, {32'b0, modelLo});
        check("mt_busy", {63'b0, busy}, 64'd0);
        check("mt_done", {63'b0, done}, 64'd0);
    endtask

    initial begin
        logic [2:0] ro;
        logic [31:0] ra, rb;
        repeat (2) @(negedge clk);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", {62'b0, busy, done}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        runOp(3'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        runOp(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        runMove(1'b1, 32'h1234_5678);
        runMove(1'b0, 32'hCAFE_F00D);
        runOp(3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp(3'd3, 32'd7, 32'd2, 64'h0000_0001_0000_0003);
        runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        runOp(3'd3, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF);
        runOp(3'd2, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);
        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            runOp(ro, ra, rb, model(ro, ra, rb));
        end
        runMove(1'b1, 32'hA5A5_0001);
        // flushed op with ignored starts while busy
`ifdef MDU_FAST_MULT_EN
        op = 3'd3;
`else
        op = 3'd0;
`endif
        start = 1'b1;
        src1 = 32'd3;
        src2 = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        op = 3'd3;
        src1 = 32'hDEAD;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        op = 3'd4;
        src1 = 32'hBEEF;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("busy_before_flush", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("busy_after_flush", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_hilo", {hi, lo}, {modelHi, modelLo});
        flush = 1'b1;
        start = 1'b1;
        op = 3'd5;
        src1 = 32'h0BAD_0BAD;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_idle", {hi, lo}, {modelHi, modelLo});
        check("flush_start_busy", {63'b0, busy}, 64'd0);
        // asynchronous reset in the middle of a divide
        start = 1'b1;
        op = 3'd2;
        src1 = 32'hFFFF_FF9C;
        src2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("busy_before_reset", {63'b0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_hilo", {hi, lo}, 64'd0);
        check("async_reset_flags", {62'b0, busy, done}, 64'd0);
        modelHi = '0;
        modelLo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runOp(3'd1, 32'd6, 32'd7, 64'd42);
        @(negedge clk);
        check("final_done_low", {63'b0, done}, 64'd0);
        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit (MDU) for the MIPS core, sitting beside the combinational ALU in the EX stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests and owns the architectural HI/LO registers.
- The pipeline stalls on busy and reads HI/LO for MFHI/MFLO.
- Multi-cycle counterpart to the single-cycle ALU.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled each rising edge.
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op.
- src1  input  WIDTH  multiplicand / dividend / MTHI-MTLO data.
- src2  input  WIDTH  multiplier / divisor.
- flush  input  1  cancel in-flight operation (exception/branch squash).
- busy  output  1  operation in progress; pipeline must stall MDU ops and MFHI/MFLO.
- done  output  1  one-cycle pulse when HI/LO are updated by a mul/div.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n low, asynchronous): hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0. Reset mid-operation abandons the operation; no done.
- Acceptance: an op is accepted at edge E0 when start=1, busy=0, flush=0. Start while busy is ignored, including MTHI/MTLO. An op of 6/7 is a no-op.
- MTHI/MTLO: hi (or lo) <= src1 at E0. No busy, no done. The other register is unchanged.
- FSM states: IDLE -> RUN (accept mul/div at E0) -> FIX -> IDLE.
  - RUN: one radix-2 step per edge, E1..E_WIDTH. Multiply is shift-add on operand magnitudes. Divide is restoring division on operand magnitudes.
  - FIX (edge E_WIDTH+1): apply sign correction, write hi/lo, pulse done=1 for exactly one cycle, busy=0.
  - Latency: WIDTH+1 edges after acceptance (33 at default). busy=1 from after E0 through E_WIDTH+1 exclusive.
- Signed ops (MULT/DIV): operands are converted to magnitude at E0; the result sign is recorded.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product.
- DIV/DIVU: lo = quotient, hi = remainder. Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: hi = src1, lo = all ones. This is deterministic; the full latency is still taken.
- DIV overflow (most-negative / -1): lo = 0x80000000, hi = 0.
- Operand capture: operands are registered at E0; later changes on src1/src2 have no effect.
- flush: when sampled high while busy, the FSM returns to IDLE at that edge. hi/lo are unchanged, no done, and busy=0 the next cycle.
  - If flush and FIX coincide, flush wins: no write, no done.
  - If flush and start coincide in IDLE, start is ignored.
- Back-to-back: a new start is accepted in the cycle done is high (busy=0 then).

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- When defined: MULT/MULTU use a single registered multiply. hi/lo are written and done pulses at E1; busy is high only for the cycle between E0 and E1. Divide is unchanged.
- When undefined: multiply uses the iterative WIDTH+1 latency above.
- Results are identical in both builds.

Test Plan:
- MULT src1=0xFFFFFFFD (-3), src2=7 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB. done high exactly one cycle; busy high for 33 cycles.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MTHI src1=0x12345678 -> hi=0x12345678 next cycle, lo unchanged, busy/done stay 0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> hi=5, lo=0xFFFFFFFF after 33 edges.
- Start MULT 3*4; at cycle 10 assert start with DIVU (ignored) and change src1; flush at cycle 20 -> busy=0 next cycle, no done, hi/lo keep prior values.
- Start DIV, drop rst_n at cycle 15 -> hi=lo=0, busy=done=0 immediately. After release, MULTU 6*7 -> lo=42, hi=0. With MDU_FAST_MULT_EN the same product arrives with done at E1.
